// File: rtl/routex_src_arb.sv
// routex_src_arb: frame-granular round-robin arbiter and framer in front of one router
// input port. Each frame is granted to a single source and sent as a header beat, a length
// beat, then the granted source's payload beats through one registered valid/ready stage.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req                 per-source frame request, held until its gnt bit rises
//   req_dest, req_len   per-source destination / payload length in 64-bit words
//   pld, pld_valid      per-source payload beat and valid
//   pld_ready           payload beat taken (granted source only, payload phase only)
//   gnt, gnt_id         registered one-hot grant and its index
//   frame_done          one-cycle pulse when the last payload beat of a frame is loaded
//   d, d_valid, d_ready router-side beat, valid and ready
module routex_src_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned REQ_W   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0][7:0]       req_dest,
  input  logic [NUM_REQ-1:0][31:0]      req_len,
  input  logic [NUM_REQ-1:0][7:0][63:0] pld,
  input  logic [NUM_REQ-1:0]            pld_valid,
  output logic [NUM_REQ-1:0]            pld_ready,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [REQ_W-1:0]              gnt_id,
  output logic                          frame_done,
  output logic [7:0][63:0]              d,
  output logic                          d_valid,
  input  logic                          d_ready
);

  typedef enum logic [1:0] {StIdle, StLen, StPld} state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [REQ_W-1:0]   gnt_id_q;
  logic [REQ_W-1:0]   ptr_q;
  logic               frame_done_q;
  logic [7:0][63:0]   d_q;
  logic               d_valid_q;
  logic [31:0]        len_q;
  logic [29:0]        cnt_q;

  // The output register can take a new beat when empty or being drained this cycle.
  logic out_free;
  assign out_free = ~d_valid_q | d_ready;

  // Round-robin pick: first requester at or after ptr_q, searching cyclically.
  logic               sel_found;
  logic [REQ_W-1:0]   sel_idx;
  logic [REQ_W-1:0]   cand;
  logic [NUM_REQ-1:0] sel_oh;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_oh    = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = REQ_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
    sel_oh[sel_idx] = sel_found;
  end

  logic [7:0][63:0] hdr_beat;
  logic [7:0][63:0] len_beat;

  always_comb begin
    hdr_beat    = '0;
    hdr_beat[7] = {8'h01, 48'h0, req_dest[sel_idx]};
    len_beat    = '0;
    len_beat[7] = {8'h00, 24'h0, len_q};
  end

  // Payload beats = max(1, ceil(len/8)); the 33-bit sum keeps len near 2^32 from wrapping.
  logic [32:0] len_round;
  logic [29:0] words;
  logic [29:0] cnt_init;

  assign len_round = {1'b0, len_q} + 33'd7;
  assign words     = 30'(len_round >> 3);
  assign cnt_init  = (words == '0) ? 30'd1 : words;

  logic pld_fire;
  assign pld_fire = (state_q == StPld) && out_free && pld_valid[gnt_id_q];

  always_comb begin
    pld_ready = '0;
    if (state_q == StPld) begin
      pld_ready[gnt_id_q] = out_free;
    end
  end

  logic [REQ_W-1:0] ptr_next;
  assign ptr_next = (gnt_id_q == REQ_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      ptr_q        <= '0;
      frame_done_q <= 1'b0;
      d_q          <= '0;
      d_valid_q    <= 1'b0;
      len_q        <= '0;
      cnt_q        <= '0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (out_free && sel_found) begin
            gnt_q     <= sel_oh;
            gnt_id_q  <= sel_idx;
            len_q     <= req_len[sel_idx];
            d_q       <= hdr_beat;
            d_valid_q <= 1'b1;
            state_q   <= StLen;
          end else if (out_free) begin
            d_valid_q <= 1'b0;
          end
        end
        StLen: begin
          if (out_free) begin
            d_q       <= len_beat;
            d_valid_q <= 1'b1;
            cnt_q     <= cnt_init;
            state_q   <= StPld;
          end
        end
        StPld: begin
          if (pld_fire) begin
            d_q       <= pld[gnt_id_q];
            d_valid_q <= 1'b1;
            cnt_q     <= cnt_q - 30'd1;
            if (cnt_q == 30'd1) begin
              frame_done_q <= 1'b1;
              gnt_q        <= '0;
              ptr_q        <= ptr_next;
              state_q      <= StIdle;
            end
          end else if (out_free) begin
            d_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign gnt_id     = gnt_id_q;
  assign frame_done = frame_done_q;
  assign d          = d_q;
  assign d_valid    = d_valid_q;

endmodule

// File: tb/tb_routex_src_arb.sv
// Testbench for routex_src_arb: table of single-frame vectors, hand-written multi-cycle
// sequences (rotation, backpressure, source stall, max length, async reset) and a
// randomized run checked against a beat-stream model of the framing rules.
module tb_routex_src_arb;
  localparam int unsigned N = 4;
  localparam int unsigned W = 2;
  typedef logic [511:0] beat_t;

  typedef struct {
    int             src;
    logic [7:0]     dest;
    logic [31:0]    len;
    int             nb;
    logic [63:0]    hdr;
    logic [63:0]    lenw;
    logic [N-1:0]   gnt;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N-1:0]            req;
  logic [N-1:0][7:0]       req_dest;
  logic [N-1:0][31:0]      req_len;
  logic [N-1:0][7:0][63:0] pld;
  logic [N-1:0]            pld_valid;
  logic [N-1:0]            pld_ready;
  logic [N-1:0]            gnt;
  logic [W-1:0]            gnt_id;
  logic                    frame_done;
  logic [7:0][63:0]        d;
  logic                    d_valid;
  logic                    d_ready;

  always #5 clk = ~clk;

  routex_src_arb #(.NUM_REQ(N), .REQ_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_dest(req_dest), .req_len(req_len),
    .pld(pld), .pld_valid(pld_valid), .pld_ready(pld_ready), .gnt(gnt), .gnt_id(gnt_id),
    .frame_done(frame_done), .d(d), .d_valid(d_valid), .d_ready(d_ready)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          frm [N];
  int          beat[N];
  logic [7:0]  dest_tab[N][16];
  logic [31:0] len_tab [N][16];
  logic [N-1:0] fire;
  beat_t       got[$];
  beat_t       exp_q[$];
  int          done_q[$];

  function automatic beat_t pay(input int src, input int f, input int b);
    beat_t r;
    for (int l = 0; l < 8; l++) r[l*64 +: 64] = {8'(src), 8'(f), 16'(b), 8'(l), 24'hC0FFEE};
    return r;
  endfunction

  function automatic beat_t hdr_of(input logic [7:0] dest);
    beat_t r;
    r = '0;
    r[511:448] = {8'h01, 48'h0, dest};
    return r;
  endfunction

  function automatic beat_t lenb_of(input logic [31:0] len);
    beat_t r;
    r = '0;
    r[511:448] = {32'h0, len};
    return r;
  endfunction

  function automatic int nbeats(input longint len);
    if (len == 0) return 1;
    return int'((len + 7) / 8);
  endfunction

  task automatic check(input string name, input beat_t act, input beat_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input string name);
    for (int c = 0; c < 20 && gnt == '0; c++) tick();
    n_checks++;
    if (gnt == '0) begin
      n_fail++;
      $display("FAIL %s: no grant within 20 cycles", name);
    end
  endtask

  task automatic wait_got(input int n, input int limit, input string name);
    for (int c = 0; c < limit && got.size() < n; c++) tick();
    n_checks++;
    if (got.size() < n) begin
      n_fail++;
      $display("FAIL %s: got %0d beats, expected %0d", name, got.size(), n);
    end
  endtask

  task automatic wait_done(input int limit, input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < limit && !seen; c++) begin
      tick();
      seen = frame_done;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: no frame_done within %0d cycles", name, limit);
    end
  endtask

  task automatic add_frame(input int src, input int f);
    exp_q.push_back(hdr_of(dest_tab[src][f%16]));
    exp_q.push_back(lenb_of(len_tab[src][f%16]));
    for (int b = 0; b < nbeats(longint'(len_tab[src][f%16])); b++) exp_q.push_back(pay(src, f, b));
  endtask

  task automatic check_stream(input string name);
    n_checks++;
    if (got.size() < exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d beats, expected %0d", name, got.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got.size(); k++)
      check($sformatf("%s_beat%0d", name, k), got[k], exp_q[k]);
  endtask

  // Source model: each source presents beat `beat` of its frame `frm` and advances on accept.
  initial begin
    for (int i = 0; i < N; i++) begin
      frm[i]  = 0;
      beat[i] = 0;
    end
    fire     = '0;
    pld      = '0;
    req_dest = '0;
    req_len  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!rst_n) begin
          beat[i] = 0;
        end else begin
          if (fire[i]) beat[i]++;
          if (frame_done && gnt_id == W'(i)) begin
            frm[i]++;
            beat[i] = 0;
          end
        end
        pld[i]      = pay(i, frm[i], beat[i]);
        req_dest[i] = dest_tab[i][frm[i]%16];
        req_len[i]  = len_tab[i][frm[i]%16];
      end
    end
  end

  // Router-side monitor plus a per-cycle pld_ready exclusivity check.
  always @(negedge clk) begin
    fire = pld_valid & pld_ready;
    if (rst_n && d_valid && d_ready) got.push_back(d);
    if (rst_n && frame_done) done_q.push_back(int'(gnt_id));
    if (rst_n) begin
      n_checks++;
      if ((pld_ready & ~gnt) != '0 || $countones(pld_ready) > 1) begin
        n_fail++;
        $display("FAIL pld_ready_excl: pld_ready=%b gnt=%b", pld_ready, gnt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int    f;
    int    f1;
    int    f0[N];
    bit    seen;
    bit    gnt_bad;
    beat_t hold_d;
    logic  hold_v;
    vec_t  vecs[5];

    vecs[0] = '{2, 8'h2A, 32'd20, 3, 64'h0100_0000_0000_002A, 64'h0000_0000_0000_0014, 4'b0100};
    vecs[1] = '{0, 8'h11, 32'd0,  1, 64'h0100_0000_0000_0011, 64'h0000_0000_0000_0000, 4'b0001};
    vecs[2] = '{3, 8'hFF, 32'd8,  1, 64'h0100_0000_0000_00FF, 64'h0000_0000_0000_0008, 4'b1000};
    vecs[3] = '{1, 8'h05, 32'd9,  2, 64'h0100_0000_0000_0005, 64'h0000_0000_0000_0009, 4'b0010};
    vecs[4] = '{2, 8'h80, 32'd17, 3, 64'h0100_0000_0000_0080, 64'h0000_0000_0000_0011, 4'b0100};

    rst_n     = 1'b0;
    req       = '0;
    pld_valid = '0;
    d_ready   = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 16; j++) begin
        dest_tab[i][j] = '0;
        len_tab[i][j]  = '0;
      end
    do_reset();
    check("rst_d", d, '0);
    check("rst_d_valid", d_valid, 0);
    check("rst_gnt", gnt, 0);
    check("rst_gnt_id", gnt_id, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pld_ready", pld_ready, 0);

    // Single-frame vectors, including the length boundaries.
    pld_valid = '1;
    for (int v = 0; v < 5; v++) begin
      f = frm[vecs[v].src];
      dest_tab[vecs[v].src][f%16] = vecs[v].dest;
      len_tab[vecs[v].src][f%16]  = vecs[v].len;
      got.delete();
      tick();
      req = vecs[v].gnt;
      wait_gnt($sformatf("tbl%0d_gnt_wait", v));
      req = '0;
      check($sformatf("tbl%0d_gnt", v), gnt, vecs[v].gnt);
      check($sformatf("tbl%0d_gnt_id", v), gnt_id, vecs[v].src);
      check($sformatf("tbl%0d_hdr", v), d, {vecs[v].hdr, 448'h0});
      gnt_bad = 1'b0;
      seen    = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        tick();
        seen = frame_done;
        if (!seen && gnt != vecs[v].gnt) gnt_bad = 1'b1;
      end
      check($sformatf("tbl%0d_done", v), seen, 1);
      check($sformatf("tbl%0d_gnt_held", v), gnt_bad, 0);
      check($sformatf("tbl%0d_last_load", v), d, pay(vecs[v].src, f, vecs[v].nb - 1));
      check($sformatf("tbl%0d_gnt_clear", v), gnt, 0);
      tick();
      check($sformatf("tbl%0d_done_pulse", v), frame_done, 0);
      check($sformatf("tbl%0d_nbeats", v), got.size(), 2 + vecs[v].nb);
      exp_q.delete();
      exp_q.push_back({vecs[v].hdr, 448'h0});
      exp_q.push_back({vecs[v].lenw, 448'h0});
      for (int b = 0; b < vecs[v].nb; b++) exp_q.push_back(pay(vecs[v].src, f, b));
      check_stream($sformatf("tbl%0d", v));
    end

    // Rotation with all sources requesting: 0,1,2,3,0 and no bubbles.
    do_reset();
    for (int i = 0; i < N; i++) begin
      f0[i] = frm[i];
      for (int k = 0; k < 3; k++) begin
        len_tab[i][(f0[i]+k)%16]  = 32'd8;
        dest_tab[i][(f0[i]+k)%16] = 8'(8'h40 + i);
      end
    end
    got.delete();
    done_q.delete();
    exp_q.delete();
    for (int k = 0; k < 5; k++) add_frame(k % N, f0[k % N] + k / N);
    tick();
    req = '1;
    f = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (!d_valid) f++;
    end
    tick();
    check("rr_bubbles", f, 0);
    check_stream("rr");
    check("rr_done_cnt", done_q.size() >= 5, 1);
    for (int k = 0; k < 5 && k < done_q.size(); k++)
      check($sformatf("rr_order%0d", k), done_q[k], k % N);
    req = '0;

    // Backpressure mid-payload: output held, source not accepted.
    do_reset();
    f = frm[2];
    dest_tab[2][f%16] = 8'h33;
    len_tab[2][f%16]  = 32'd40;
    got.delete();
    exp_q.delete();
    add_frame(2, f);
    tick();
    req = 4'b0100;
    wait_gnt("bp_gnt_wait");
    req = '0;
    wait_got(4, 30, "bp_pre");
    d_ready = 1'b0;
    #1;
    hold_d = d;
    hold_v = d_valid;
    check("bp_hold_beat", hold_d, pay(2, f, 2));
    check("bp_hold_valid", hold_v, 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp_d%0d", c), d, hold_d);
      check($sformatf("bp_v%0d", c), d_valid, hold_v);
      check($sformatf("bp_rdy%0d", c), pld_ready[2], 0);
    end
    d_ready = 1'b1;
    wait_done(30, "bp_done");
    tick();
    check("bp_nbeats", got.size(), 7);
    check_stream("bp");

    // Source stall with req dropped mid-frame: drains, then resumes in order.
    do_reset();
    f = frm[1];
    dest_tab[1][f%16] = 8'h51;
    len_tab[1][f%16]  = 32'd40;
    got.delete();
    exp_q.delete();
    add_frame(1, f);
    tick();
    req = 4'b0010;
    wait_got(3, 30, "st_pre");
    pld_valid[1] = 1'b0;
    req          = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("st_drain%0d", c), d_valid, 0);
    end
    check("st_rdy", pld_ready[1], 1);
    pld_valid = '1;
    wait_done(30, "st_done");
    tick();
    tick();
    check("st_nbeats", got.size(), 7);
    check_stream("st");
    check("st_idle_gnt", gnt, 0);
    check("st_idle_valid", d_valid, 0);

    // Maximum length: beat count must not overflow.
    do_reset();
    f = frm[0];
    dest_tab[0][f%16] = 8'h01;
    len_tab[0][f%16]  = 32'hFFFF_FFFF;
    pld_valid = '0;
    tick();
    req = 4'b0001;
    wait_gnt("max_gnt_wait");
    req = '0;
    tick();
    check("max_len_beat", d, lenb_of(32'hFFFF_FFFF));
    check("max_cnt", dut.cnt_q, 30'h2000_0000);
    pld_valid = '1;

    // Async reset mid-payload, then restart from pointer 0.
    do_reset();
    f = frm[2];
    dest_tab[2][f%16] = 8'h62;
    len_tab[2][f%16]  = 32'd8;
    tick();
    req = 4'b0100;
    wait_gnt("ar_first_gnt");
    req = '0;
    wait_done(20, "ar_first_done");
    tick();
    f = frm[3];
    dest_tab[3][f%16] = 8'h73;
    len_tab[3][f%16]  = 32'd40;
    f1 = frm[1];
    dest_tab[1][f1%16] = 8'h71;
    len_tab[1][f1%16]  = 32'd8;
    got.delete();
    tick();
    req = 4'b1010;
    wait_gnt("ar_gnt3_wait");
    check("ar_gnt_id3", gnt_id, 3);
    wait_got(4, 30, "ar_pre");
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_d_valid", d_valid, 0);
    check("ar_gnt", gnt, 0);
    check("ar_pld_ready", pld_ready, 0);
    check("ar_frame_done", frame_done, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    got.delete();
    exp_q.delete();
    add_frame(1, f1);
    wait_gnt("ar_regnt_wait");
    req = '0;
    check("ar_regnt_id", gnt_id, 1);
    check("ar_regnt_hdr", d, hdr_of(8'h71));
    wait_done(20, "ar_done");
    tick();
    check_stream("ar");

    // Randomized: all sources always requesting, random stalls on both sides.
    do_reset();
    for (int i = 0; i < N; i++) begin
      f0[i] = frm[i];
      for (int k = 0; k < 8; k++) begin
        len_tab[i][(f0[i]+k)%16]  = 32'($urandom_range(0, 40));
        dest_tab[i][(f0[i]+k)%16] = 8'($urandom);
      end
    end
    got.delete();
    done_q.delete();
    exp_q.delete();
    for (int k = 0; k < 24; k++) add_frame(k % N, f0[k % N] + k / N);
    tick();
    req = '1;
    for (int c = 0; c < 4000 && got.size() < exp_q.size(); c++) begin
      d_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) pld_valid[i] = ($urandom_range(0, 3) != 0);
      tick();
    end
    req       = '0;
    d_ready   = 1'b1;
    pld_valid = '1;
    check_stream("rnd");
    check("rnd_done_cnt", done_q.size() >= 24, 1);
    for (int k = 0; k < 24 && k < done_q.size(); k++)
      check($sformatf("rnd_order%0d", k), done_q[k], k % N);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
